// File: rtl/axi_mctp_write_sink.sv
// AXI4 write slave that terminates MCTP-over-PCIe VDM bursts: header check, MCTP sequence tracking, payload streaming.
// Optional per-burst error counters are enabled by defining AXI_MCTP_SINK_ERR_CNT_EN.
module axi_mctp_write_sink #(
  parameter logic [15:0] EXP_VENDOR_ID = 16'hB41A,
  parameter logic [7:0]  EXP_MSG_CODE  = 8'h7F,
  parameter logic [3:0]  EXP_HDR_VER   = 4'h1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [6:0]   I_AWID,
  input  logic [63:0]  I_AWADDR,
  input  logic [7:0]   I_AWLEN,
  input  logic         I_AWVALID,
  output logic         O_AWREADY,
  input  logic [255:0] I_WDATA,
  input  logic         I_WLAST,
  input  logic         I_WVALID,
  output logic         O_WREADY,
  output logic [6:0]   O_BID,
  output logic [1:0]   O_BRESP,
  output logic         O_BVALID,
  input  logic         I_BREADY,
  output logic [127:0] O_HDR,
  output logic         O_HDR_VALID,
  output logic [255:0] O_PLD_DATA,
  output logic         O_PLD_VALID,
  output logic         O_PLD_FIRST,
  output logic         O_PLD_LAST,
`ifdef AXI_MCTP_SINK_ERR_CNT_EN
  output logic [15:0]  O_HDR_ERR_CNT,
  output logic [15:0]  O_SEQ_ERR_CNT,
  output logic [15:0]  O_LAST_ERR_CNT,
`endif
  output logic         O_HDR_ERR,
  output logic         O_SEQ_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t       state_q, state_d;
  logic         awready_q, awready_d;
  logic [6:0]   id_q, id_d;
  logic [7:0]   len_q, len_d;
  logic [7:0]   beat_cnt_q, beat_cnt_d;
  logic         burst_err_q, burst_err_d;
  logic         bvalid_q, bvalid_d;
  logic [1:0]   bresp_q, bresp_d;
  logic [127:0] hdr_q, hdr_d;
  logic         hdr_valid_q, hdr_valid_d;
  logic [255:0] pld_data_q, pld_data_d;
  logic         pld_valid_q, pld_valid_d;
  logic         pld_first_q, pld_first_d;
  logic         pld_last_q, pld_last_d;
  logic         hdr_err_q, hdr_err_d;
  logic         seq_err_q, seq_err_d;
  logic         in_msg_q, in_msg_d;
  logic [1:0]   exp_seq_q, exp_seq_d;
  logic [3:0]   exp_tag_q, exp_tag_d;

  logic         hdr_hit, seq_hit, last_hit;
  logic         beat0, at_last, hdr_ok;
  logic         som, eom;
  logic [1:0]   seq;
  logic [3:0]   to_tag;

  // The write address carries no information for this sink.
  logic unused_awaddr;
  assign unused_awaddr = ^I_AWADDR;

  assign som    = I_WDATA[127];
  assign eom    = I_WDATA[126];
  assign seq    = I_WDATA[125:124];
  assign to_tag = I_WDATA[123:120];
  assign hdr_ok = (I_WDATA[7:5] == 3'b011) && (I_WDATA[4:3] == 2'b10) &&
                  (I_WDATA[63:56] == EXP_MSG_CODE) && (I_WDATA[95:80] == EXP_VENDOR_ID) &&
                  (I_WDATA[99:96] == EXP_HDR_VER);
  assign beat0   = (beat_cnt_q == 8'd0);
  assign at_last = (beat_cnt_q == len_q);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    burst_err_d = burst_err_q;
    bresp_d     = bresp_q;
    hdr_d       = hdr_q;
    hdr_valid_d = 1'b0;
    pld_data_d  = pld_data_q;
    pld_valid_d = 1'b0;
    pld_first_d = 1'b0;
    pld_last_d  = 1'b0;
    hdr_err_d   = hdr_err_q;
    seq_err_d   = seq_err_q;
    in_msg_d    = in_msg_q;
    exp_seq_d   = exp_seq_q;
    exp_tag_d   = exp_tag_q;
    hdr_hit     = 1'b0;
    seq_hit     = 1'b0;
    last_hit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_AWVALID && awready_q) begin
          id_d        = I_AWID;
          len_d       = I_AWLEN;
          beat_cnt_d  = 8'd0;
          burst_err_d = 1'b0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (I_WVALID) begin
          pld_valid_d = 1'b1;
          pld_first_d = beat0;
          pld_last_d  = at_last;
          pld_data_d  = beat0 ? {128'h0, I_WDATA[255:128]} : I_WDATA;
          beat_cnt_d  = beat_cnt_q + 8'd1;
          if (beat0) begin
            hdr_d       = I_WDATA[127:0];
            hdr_valid_d = 1'b1;
            if (!hdr_ok) begin
              hdr_hit = 1'b1;
            end else if (som) begin
              // SOM always (re)starts a message, even one already in flight.
              exp_seq_d = seq + 2'd1;
              exp_tag_d = to_tag;
              in_msg_d  = !eom;
            end else if (!in_msg_q) begin
              seq_hit = 1'b1;
            end else if ((seq == exp_seq_q) && (to_tag == exp_tag_q)) begin
              exp_seq_d = exp_seq_q + 2'd1;
              if (eom) in_msg_d = 1'b0;
            end else begin
              seq_hit  = 1'b1;
              in_msg_d = 1'b0;
            end
          end
          last_hit    = (I_WLAST != at_last);
          if (hdr_hit) hdr_err_d = 1'b1;
          if (seq_hit) seq_err_d = 1'b1;
          burst_err_d = burst_err_q | hdr_hit | seq_hit | last_hit;
          // Either a WLAST or the final counted beat closes the burst.
          if (I_WLAST || at_last) begin
            state_d = S_RESP;
            bresp_d = burst_err_d ? 2'b10 : 2'b00;
          end
        end
      end
      S_RESP: begin
        if (I_BREADY && bvalid_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = (state_d == S_IDLE);
    bvalid_d  = (state_d == S_RESP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      awready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      burst_err_q <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= '0;
      hdr_q       <= '0;
      hdr_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pld_valid_q <= 1'b0;
      pld_first_q <= 1'b0;
      pld_last_q  <= 1'b0;
      hdr_err_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      in_msg_q    <= 1'b0;
      exp_seq_q   <= '0;
      exp_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      id_q        <= id_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_err_q <= burst_err_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      hdr_q       <= hdr_d;
      hdr_valid_q <= hdr_valid_d;
      pld_data_q  <= pld_data_d;
      pld_valid_q <= pld_valid_d;
      pld_first_q <= pld_first_d;
      pld_last_q  <= pld_last_d;
      hdr_err_q   <= hdr_err_d;
      seq_err_q   <= seq_err_d;
      in_msg_q    <= in_msg_d;
      exp_seq_q   <= exp_seq_d;
      exp_tag_q   <= exp_tag_d;
    end
  end

`ifdef AXI_MCTP_SINK_ERR_CNT_EN
  logic [15:0] hdr_cnt_q, seq_cnt_q, last_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Each hit flag fires at most once per burst, so the counters count bursts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hdr_cnt_q  <= '0;
      seq_cnt_q  <= '0;
      last_cnt_q <= '0;
    end else begin
      if (hdr_hit)  hdr_cnt_q  <= sat_inc(hdr_cnt_q);
      if (seq_hit)  seq_cnt_q  <= sat_inc(seq_cnt_q);
      if (last_hit) last_cnt_q <= sat_inc(last_cnt_q);
    end
  end

  assign O_HDR_ERR_CNT  = hdr_cnt_q;
  assign O_SEQ_ERR_CNT  = seq_cnt_q;
  assign O_LAST_ERR_CNT = last_cnt_q;
`endif

  assign O_AWREADY   = awready_q;
  assign O_WREADY    = (state_q == S_DATA);
  assign O_BID       = id_q;
  assign O_BRESP     = bresp_q;
  assign O_BVALID    = bvalid_q;
  assign O_HDR       = hdr_q;
  assign O_HDR_VALID = hdr_valid_q;
  assign O_PLD_DATA  = pld_data_q;
  assign O_PLD_VALID = pld_valid_q;
  assign O_PLD_FIRST = pld_first_q;
  assign O_PLD_LAST  = pld_last_q;
  assign O_HDR_ERR   = hdr_err_q;
  assign O_SEQ_ERR   = seq_err_q;

endmodule

// File: tb/tb_axi_mctp_write_sink.sv
// Self-checking bench for axi_mctp_write_sink: directed scenarios plus randomized bursts against a burst-level model.
module tb_axi_mctp_write_sink;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [6:0]   I_AWID;
  logic [63:0]  I_AWADDR;
  logic [7:0]   I_AWLEN;
  logic         I_AWVALID;
  logic         O_AWREADY;
  logic [255:0] I_WDATA;
  logic         I_WLAST;
  logic         I_WVALID;
  logic         O_WREADY;
  logic [6:0]   O_BID;
  logic [1:0]   O_BRESP;
  logic         O_BVALID;
  logic         I_BREADY;
  logic [127:0] O_HDR;
  logic         O_HDR_VALID;
  logic [255:0] O_PLD_DATA;
  logic         O_PLD_VALID;
  logic         O_PLD_FIRST;
  logic         O_PLD_LAST;
  logic         O_HDR_ERR;
  logic         O_SEQ_ERR;
`ifdef AXI_MCTP_SINK_ERR_CNT_EN
  logic [15:0]  O_HDR_ERR_CNT, O_SEQ_ERR_CNT, O_LAST_ERR_CNT;
  logic [449:0] all_outs;
  assign all_outs = {O_AWREADY, O_WREADY, O_BID, O_BRESP, O_BVALID, O_HDR, O_HDR_VALID, O_PLD_DATA,
                     O_PLD_VALID, O_PLD_FIRST, O_PLD_LAST, O_HDR_ERR, O_SEQ_ERR,
                     O_HDR_ERR_CNT, O_SEQ_ERR_CNT, O_LAST_ERR_CNT};
`else
  logic [401:0] all_outs;
  assign all_outs = {O_AWREADY, O_WREADY, O_BID, O_BRESP, O_BVALID, O_HDR, O_HDR_VALID, O_PLD_DATA,
                     O_PLD_VALID, O_PLD_FIRST, O_PLD_LAST, O_HDR_ERR, O_SEQ_ERR};
`endif

  always #5 clk = ~clk;

  axi_mctp_write_sink dut (
    .i_clk(clk), .i_reset(i_reset),
    .I_AWID(I_AWID), .I_AWADDR(I_AWADDR), .I_AWLEN(I_AWLEN), .I_AWVALID(I_AWVALID), .O_AWREADY(O_AWREADY),
    .I_WDATA(I_WDATA), .I_WLAST(I_WLAST), .I_WVALID(I_WVALID), .O_WREADY(O_WREADY),
    .O_BID(O_BID), .O_BRESP(O_BRESP), .O_BVALID(O_BVALID), .I_BREADY(I_BREADY),
    .O_HDR(O_HDR), .O_HDR_VALID(O_HDR_VALID),
    .O_PLD_DATA(O_PLD_DATA), .O_PLD_VALID(O_PLD_VALID), .O_PLD_FIRST(O_PLD_FIRST), .O_PLD_LAST(O_PLD_LAST),
`ifdef AXI_MCTP_SINK_ERR_CNT_EN
    .O_HDR_ERR_CNT(O_HDR_ERR_CNT), .O_SEQ_ERR_CNT(O_SEQ_ERR_CNT), .O_LAST_ERR_CNT(O_LAST_ERR_CNT),
`endif
    .O_HDR_ERR(O_HDR_ERR), .O_SEQ_ERR(O_SEQ_ERR)
  );

  typedef struct {
    logic [255:0] data;
    logic         first;
    logic         last;
  } pld_t;

  int errors = 0;
  int checks = 0;

  pld_t         obs_q[$];
  pld_t         exp_q[$];
  pld_t         mon_p;
  int           hdr_pulses;
  logic [255:0] beat_mem [0:255];

  // Reference model state (message context, sticky flags, per-burst expectations)
  bit           m_in_msg, m_hdr_err, m_seq_err;
  logic [1:0]   m_exp_seq;
  logic [3:0]   m_exp_tag;
  logic [1:0]   m_bresp;
  logic [127:0] m_hdr;
  int           m_hdr_cnt, m_seq_cnt, m_last_cnt;

  // Driver observations
  logic [6:0]   o_bid;
  logic [1:0]   o_bresp;
  int           o_held;
  logic         o_post_bvalid, o_post_awready;

  always @(negedge clk) begin
    if (O_PLD_VALID) begin
      mon_p.data  = O_PLD_DATA;
      mon_p.first = O_PLD_FIRST;
      mon_p.last  = O_PLD_LAST;
      obs_q.push_back(mon_p);
    end
    if (O_HDR_VALID) hdr_pulses++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout need completion");
    $fatal(1);
  end

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mk_hdr(input bit som, input bit eom, input int seq, input int tt, input int ver);
    logic [127:0] h;
    h = {$urandom, $urandom, $urandom, $urandom};
    h[7:5]     = 3'b011;
    h[4:3]     = 2'b10;
    h[63:56]   = 8'h7F;
    h[95:80]   = 16'hB41A;
    h[99:96]   = ver[3:0];
    h[127]     = som;
    h[126]     = eom;
    h[125:124] = seq[1:0];
    h[123:120] = tt[3:0];
    return h;
  endfunction

  task automatic fill_beats(input logic [127:0] hdr, input int len);
    logic [255:0] b0;
    b0 = rand256();
    beat_mem[0] = {b0[255:128], hdr};
    for (int i = 1; i <= len; i++) beat_mem[i] = rand256();
  endtask

  task automatic model_reset();
    m_in_msg = 0; m_hdr_err = 0; m_seq_err = 0;
    m_exp_seq = '0; m_exp_tag = '0;
    m_hdr_cnt = 0; m_seq_cnt = 0; m_last_cnt = 0;
  endtask

  // Burst-level expectations computed from the header and WLAST placement.
  task automatic model_burst(input int len, input int last_idx);
    int n;
    bit err, bad, hok;
    logic [127:0] h;
    pld_t p;
    exp_q.delete();
    n = (last_idx < len) ? last_idx + 1 : len + 1;
    for (int i = 0; i < n; i++) begin
      p.data  = (i == 0) ? {128'h0, beat_mem[0][255:128]} : beat_mem[i];
      p.first = (i == 0);
      p.last  = (i == len);
      exp_q.push_back(p);
    end
    err = (last_idx != len);
    if (err) m_last_cnt++;
    h = beat_mem[0][127:0];
    m_hdr = h;
    hok = (h[7:5] == 3'b011) && (h[4:3] == 2'b10) && (h[63:56] == 8'h7F) &&
          (h[95:80] == 16'hB41A) && (h[99:96] == 4'h1);
    bad = 0;
    if (!hok) begin
      m_hdr_err = 1; err = 1; m_hdr_cnt++;
    end else begin
      if (h[127]) begin
        m_exp_seq = 2'((int'(h[125:124]) + 1) % 4);
        m_exp_tag = h[123:120];
        m_in_msg  = !h[126];
      end else if (!m_in_msg) begin
        bad = 1;
      end else if (h[125:124] == m_exp_seq && h[123:120] == m_exp_tag) begin
        m_exp_seq = 2'((int'(m_exp_seq) + 1) % 4);
        if (h[126]) m_in_msg = 0;
      end else begin
        bad = 1; m_in_msg = 0;
      end
      if (bad) begin m_seq_err = 1; err = 1; m_seq_cnt++; end
    end
    m_bresp = err ? 2'b10 : 2'b00;
  endtask

  function automatic int pld_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i])
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].first !== exp_q[i].first || obs_q[i].last !== exp_q[i].last)
        return i;
    return -1;
  endfunction

  // Runs one burst; called and returning #1 after a rising edge.
  task automatic run_burst(input logic [6:0] id, input int len, input int last_idx, input int bdelay);
    int t, n;
    obs_q.delete();
    hdr_pulses = 0;
    I_AWID = id; I_AWLEN = len[7:0]; I_AWADDR = {$urandom, $urandom}; I_AWVALID = 1'b1;
    t = 0;
    while (!O_AWREADY && t < 50) begin @(posedge clk); #1; t++; end
    if (!O_AWREADY) begin
      errors++; checks++;
      $display("FAIL aw_timeout: AWREADY got %b need 1", O_AWREADY);
    end
    @(posedge clk); #1;
    I_AWVALID = 1'b0;
    n = (last_idx < len) ? last_idx + 1 : len + 1;
    for (int i = 0; i < n; i++) begin
      I_WDATA = beat_mem[i]; I_WLAST = (i == last_idx); I_WVALID = 1'b1;
      t = 0;
      while (!O_WREADY && t < 50) begin @(posedge clk); #1; t++; end
      if (!O_WREADY) begin
        errors++; checks++;
        $display("FAIL w_timeout: WREADY beat %0d got %b need 1", i, O_WREADY);
      end
      @(posedge clk); #1;
    end
    I_WVALID = 1'b0; I_WLAST = 1'b0;
    t = 0;
    while (!O_BVALID && t < 50) begin @(posedge clk); #1; t++; end
    if (!O_BVALID) begin
      errors++; checks++;
      $display("FAIL b_timeout: BVALID got %b need 1", O_BVALID);
    end
    o_bid = O_BID; o_bresp = O_BRESP; o_held = 0;
    for (int d = 0; d < bdelay; d++) begin
      @(posedge clk); #1;
      if (O_BVALID) o_held++;
    end
    I_BREADY = 1'b1;
    @(posedge clk); #1;
    I_BREADY = 1'b0;
    o_post_bvalid = O_BVALID; o_post_awready = O_AWREADY;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    I_AWID = '0; I_AWADDR = '0; I_AWLEN = '0; I_AWVALID = 1'b0;
    I_WDATA = '0; I_WLAST = 1'b0; I_WVALID = 1'b0; I_BREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL reset_outs: got %0h need 0", all_outs); end
    i_reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (O_AWREADY !== 1'b1 || O_WREADY !== 1'b0) begin
      errors++; $display("FAIL reset_release: AWREADY/WREADY got %b%b need 10", O_AWREADY, O_WREADY);
    end
  endtask

  task automatic test_basic();
    logic [127:0] h;
    int pd;
    h = mk_hdr(1, 1, 0, 0, 1);
    fill_beats(h, 1);
    beat_mem[0][255:128] = {16{8'hAA}};
    beat_mem[1] = {32{8'hBB}};
    model_burst(1, 1);
    run_burst(7'h0, 1, 1, 0);
    checks++;
    if (o_bresp !== 2'b00 || o_bid !== 7'h0) begin
      errors++; $display("FAIL basic_b: bresp/bid got %b/%0h need 00/0", o_bresp, o_bid);
    end
    checks++;
    pd = pld_diff();
    if (pd != -1) begin errors++; $display("FAIL basic_pld: beats %0d idx %0d need %0d beats ok", obs_q.size(), pd, exp_q.size()); end
    checks++;
    if (obs_q.size() == 2 && (obs_q[0].data !== {128'h0, {16{8'hAA}}} || obs_q[1].data !== {32{8'hBB}} || obs_q[1].last !== 1'b1)) begin
      errors++; $display("FAIL basic_pattern: beat0 %0h beat1 %0h", obs_q[0].data, obs_q[1].data);
    end
    checks++;
    if (hdr_pulses != 1 || O_HDR !== h) begin
      errors++; $display("FAIL basic_hdr: pulses %0d hdr %0h need 1 %0h", hdr_pulses, O_HDR, h);
    end
    checks++;
    if (O_HDR_ERR !== 1'b0 || O_SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL basic_flags: hdr/seq err got %b%b need 00", O_HDR_ERR, O_SEQ_ERR);
    end
  endtask

  task automatic test_hdr_err();
    int pd;
    fill_beats(mk_hdr(1, 1, 0, 0, 2), 1);
    model_burst(1, 1);
    run_burst(7'h11, 1, 1, 0);
    checks++;
    if (o_bresp !== 2'b10 || o_bresp !== m_bresp) begin
      errors++; $display("FAIL hdr_err_bresp: got %b need 10", o_bresp);
    end
    checks++;
    if (O_HDR_ERR !== 1'b1) begin errors++; $display("FAIL hdr_err_flag: got %b need 1", O_HDR_ERR); end
    checks++;
    pd = pld_diff();
    if (pd != -1) begin errors++; $display("FAIL hdr_err_pld: beats %0d idx %0d need %0d", obs_q.size(), pd, exp_q.size()); end
  endtask

  task automatic test_seq();
    // som, eom, seq: SEQ 0..2 message, then SEQ3 -> SEQ0 wrap
    int tbl [5][3] = '{'{1, 0, 0}, '{0, 0, 1}, '{0, 1, 2}, '{1, 0, 3}, '{0, 1, 0}};
    for (int i = 0; i < 5; i++) begin
      fill_beats(mk_hdr(tbl[i][0] != 0, tbl[i][1] != 0, tbl[i][2], 3, 1), 0);
      model_burst(0, 0);
      run_burst(7'(i), 0, 0, 0);
      checks++;
      if (o_bresp !== 2'b00 || o_bresp !== m_bresp) begin
        errors++; $display("FAIL seq_ok[%0d]: bresp got %b need 00", i, o_bresp);
      end
    end
    checks++;
    if (O_SEQ_ERR !== 1'b0) begin errors++; $display("FAIL seq_ok_flag: got %b need 0", O_SEQ_ERR); end
  endtask

  task automatic test_seq_skip();
    int tbl [3][3] = '{'{1, 0, 0}, '{0, 0, 2}, '{0, 0, 3}};
    logic [1:0] need [3] = '{2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 3; i++) begin
      fill_beats(mk_hdr(tbl[i][0] != 0, tbl[i][1] != 0, tbl[i][2], 3, 1), 0);
      model_burst(0, 0);
      run_burst(7'h20, 0, 0, 0);
      checks++;
      if (o_bresp !== need[i] || o_bresp !== m_bresp) begin
        errors++; $display("FAIL seq_skip[%0d]: bresp got %b need %b", i, o_bresp, need[i]);
      end
    end
    checks++;
    if (O_SEQ_ERR !== 1'b1) begin errors++; $display("FAIL seq_skip_flag: got %b need 1", O_SEQ_ERR); end
  endtask

  task automatic test_early_last();
    int pd;
    fill_beats(mk_hdr(1, 1, 1, 5, 1), 3);
    model_burst(3, 1);
    run_burst(7'h55, 3, 1, 5);
    checks++;
    if (o_bresp !== 2'b10 || o_bid !== 7'h55) begin
      errors++; $display("FAIL early_b: bresp/bid got %b/%0h need 10/55", o_bresp, o_bid);
    end
    checks++;
    pd = pld_diff();
    if (pd != -1 || obs_q.size() != 2) begin
      errors++; $display("FAIL early_pld: beats %0d idx %0d need 2", obs_q.size(), pd);
    end
    checks++;
    if (o_held != 5) begin errors++; $display("FAIL early_hold: BVALID cycles got %0d need 5", o_held); end
    checks++;
    if (o_post_bvalid !== 1'b0 || o_post_awready !== 1'b1) begin
      errors++; $display("FAIL early_post: BVALID/AWREADY got %b%b need 01", o_post_bvalid, o_post_awready);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    fill_beats(mk_hdr(1, 0, 0, 1, 1), 3);
    I_AWID = 7'h33; I_AWLEN = 8'd3; I_AWVALID = 1'b1;
    t = 0;
    while (!O_AWREADY && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    I_AWVALID = 1'b0;
    I_WDATA = beat_mem[0]; I_WLAST = 1'b0; I_WVALID = 1'b1;
    @(posedge clk); #1;
    I_WDATA = beat_mem[1]; i_reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (all_outs !== '0) begin errors++; $display("FAIL mid_reset_outs: got %0h need 0", all_outs); end
    I_WVALID = 1'b0; i_reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (O_AWREADY !== 1'b1 || O_BVALID !== 1'b0) begin
      errors++; $display("FAIL mid_reset_release: AWREADY/BVALID got %b%b need 10", O_AWREADY, O_BVALID);
    end
    fill_beats(mk_hdr(1, 1, 2, 6, 1), 1);
    model_burst(1, 1);
    run_burst(7'h34, 1, 1, 1);
    checks++;
    if (o_bresp !== 2'b00 || o_bid !== 7'h34 || O_HDR_ERR !== 1'b0 || O_SEQ_ERR !== 1'b0) begin
      errors++; $display("FAIL mid_reset_burst: bresp %b bid %0h flags %b%b need 00 34 00", o_bresp, o_bid, O_HDR_ERR, O_SEQ_ERR);
    end
  endtask

  task automatic test_random();
    int len, last_idx, r, pd, ver, seq, tt;
    bit som, eom;
    logic [6:0] id;
    logic [127:0] h;
    for (int n = 0; n < 40; n++) begin
      len = (n == 20) ? 255 : $urandom_range(0, 7);
      r = $urandom_range(0, 9);
      if (r < 7) last_idx = len;
      else if (r == 7 && len > 0) last_idx = $urandom_range(0, len - 1);
      else if (r == 7) last_idx = len;
      else last_idx = len + 1;
      som = 1'($urandom_range(0, 1)); eom = 1'($urandom_range(0, 1));
      seq = $urandom_range(0, 3); tt = $urandom_range(0, 15);
      if (m_in_msg && $urandom_range(0, 2) != 0) begin som = 0; seq = m_exp_seq; tt = m_exp_tag; end
      ver = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : 1;
      h = mk_hdr(som, eom, seq, tt, ver);
      case ($urandom_range(0, 19))
        0: h[7:5] = 3'b010;
        1: h[4:3] = 2'b11;
        2: h[63:56] = 8'h7E;
        3: h[95:80] = 16'hB41B;
        default: ;
      endcase
      fill_beats(h, len);
      model_burst(len, last_idx);
      id = 7'($urandom_range(0, 127));
      run_burst(id, len, last_idx, $urandom_range(0, 2));
      checks++;
      if (o_bresp !== m_bresp || o_bid !== id) begin
        errors++; $display("FAIL rnd_b[%0d]: bresp/bid got %b/%0h need %b/%0h", n, o_bresp, o_bid, m_bresp, id);
      end
      checks++;
      pd = pld_diff();
      if (pd != -1) begin errors++; $display("FAIL rnd_pld[%0d]: beats %0d idx %0d need %0d", n, obs_q.size(), pd, exp_q.size()); end
      checks++;
      if (hdr_pulses != 1 || O_HDR !== m_hdr) begin
        errors++; $display("FAIL rnd_hdr[%0d]: pulses %0d hdr %0h need 1 %0h", n, hdr_pulses, O_HDR, m_hdr);
      end
      checks++;
      if (O_HDR_ERR !== m_hdr_err || O_SEQ_ERR !== m_seq_err) begin
        errors++; $display("FAIL rnd_flags[%0d]: got %b%b need %b%b", n, O_HDR_ERR, O_SEQ_ERR, m_hdr_err, m_seq_err);
      end
    end
`ifdef AXI_MCTP_SINK_ERR_CNT_EN
    checks++;
    if (O_HDR_ERR_CNT !== 16'(m_hdr_cnt) || O_SEQ_ERR_CNT !== 16'(m_seq_cnt) || O_LAST_ERR_CNT !== 16'(m_last_cnt)) begin
      errors++; $display("FAIL rnd_cnt: got %0d/%0d/%0d need %0d/%0d/%0d", O_HDR_ERR_CNT, O_SEQ_ERR_CNT,
                         O_LAST_ERR_CNT, m_hdr_cnt, m_seq_cnt, m_last_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hdr_err();
    test_seq();
    test_seq_skip();
    test_early_last();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_mctp_write_sink.md
Name: axi_mctp_write_sink

Overview:
- AXI4 write slave. Terminates the 256-bit write bursts driven by the MCTP-over-PCIe VDM write generator.
- Per burst:
  - handshakes the AW, W and B channels;
  - extracts the 128-bit TLP header carried in beat 0 bits [127:0];
  - checks the PCIe VDM and MCTP transport fields and tracks the MCTP packet sequence across SOM..EOM;
  - streams the payload out;
  - returns BRESP OKAY or SLVERR.
- Sits between the AXI interconnect and the MCTP reassembly logic.

Parameters:
- EXP_VENDOR_ID, 16'hB41A, value header[95:80] must equal.
- EXP_MSG_CODE, 8'h7F, value header[63:56] must equal.
- EXP_HDR_VER, 4'h1, value header[99:96] must equal.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- I_AWID  in  7  write ID
- I_AWADDR  in  64  write address (ignored)
- I_AWLEN  in  8  beats minus 1
- I_AWVALID  in  1  AW valid
- O_AWREADY  out  1  AW ready
- I_WDATA  in  256  write data
- I_WLAST  in  1  last beat
- I_WVALID  in  1  W valid
- O_WREADY  out  1  W ready
- O_BID  out  7  response ID
- O_BRESP  out  2  response code
- O_BVALID  out  1  B valid
- I_BREADY  in  1  B ready
- O_HDR  out  128  last captured header
- O_HDR_VALID  out  1  one-cycle pulse, header captured
- O_PLD_DATA  out  256  payload beat
- O_PLD_VALID  out  1  payload valid
- O_PLD_FIRST  out  1  beat 0 (only [127:0] meaningful)
- O_PLD_LAST  out  1  final payload beat
- O_HDR_ERR  out  1  sticky header error
- O_SEQ_ERR  out  1  sticky sequence error

Behaviour:

Reset:
- Synchronous, active-high, on i_clk only.
- All outputs reset to 0.
- State returns to IDLE. in_msg, exp_seq and exp_tag are cleared.
- Reset mid-burst abandons the burst; no B response is issued.

State machine: IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - O_AWREADY=1 (registered; first 1 the cycle after reset release). O_WREADY=0.
  - On AWVALID&AWREADY: latch AWID and AWLEN, clear beat_cnt and the per-burst error flag, go DATA. O_AWREADY drops the next cycle.
- DATA:
  - O_WREADY=1. One beat accepted per WVALID&WREADY; beat_cnt increments.
  - W data offered while in IDLE is not accepted.
- Beat 0 handling:
  - Header = WDATA[127:0] is registered into O_HDR, with O_HDR_VALID pulsed the following cycle.
  - Payload output is {128'h0, WDATA[255:128]} with O_PLD_FIRST=1.
- Beats 1..AWLEN: payload output = WDATA.
- Payload outputs are registered, 1-cycle latency from handshake, no backpressure.
- Last beat: O_PLD_LAST=1 on the beat where beat_cnt==AWLEN.
- WLAST check:
  - WLAST=1 with beat_cnt<AWLEN: the burst ends immediately (early) and the burst is marked error.
  - WLAST=0 at beat_cnt==AWLEN: the burst also ends and is marked error.
  - Either case goes to RESP.
- RESP:
  - O_BVALID=1, O_BID=latched ID.
  - O_BRESP=2'b10 if the burst error flag is set, else 2'b00.
  - Held until BREADY. On handshake, O_BVALID=0 and the block goes to IDLE, with O_AWREADY=1 the next cycle.
  - New AW is not accepted during DATA or RESP.

Header check, evaluated at beat 0:
- Required fields: fmt[7:5]==3'b011, type[4:3]==2'b10, [63:56]==EXP_MSG_CODE, [95:80]==EXP_VENDOR_ID, [99:96]==EXP_HDR_VER.
- Any mismatch sets O_HDR_ERR (sticky until reset) and the burst error flag, and skips sequence tracking.

Sequence tracking, MCTP fields SOM[127], EOM[126], SEQ[125:124], TO[123], TAG[122:120]:
- SOM=1:
  - exp_seq = SEQ+1 mod 4 (wraps 3->0); exp_tag = {TO,TAG}; in_msg = !EOM.
  - SOM while in_msg restarts the message with no error.
- SOM=0 and in_msg=0: sequence error.
- SOM=0 and in_msg=1:
  - SEQ==exp_seq and {TO,TAG}==exp_tag: exp_seq increments; EOM=1 clears in_msg.
  - Otherwise: sequence error and in_msg is cleared.
- A sequence error sets O_SEQ_ERR (sticky) and the burst error flag.

Boundary cases:
- AWLEN=0: single beat; WLAST must be 1.
- AWLEN=255 is supported.
- beat_cnt is 8 bits.

Optional Feature:
Macro AXI_MCTP_SINK_ERR_CNT_EN.
- Defined: adds outputs O_HDR_ERR_CNT[15:0], O_SEQ_ERR_CNT[15:0], O_LAST_ERR_CNT[15:0].
  - Each counter increments once per offending burst and saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the counter ports and counter logic are absent; all other behaviour is identical.

Test Plan:
1. AWID=7'h0, AWLEN=1. Beat0 header = {SOM=1,EOM=1,SEQ=0,TO=0,TAG=0, fmt 011, type 10, code 7F, vendor B41A, ver 1}, beat0[255:128]=0xAA.., beat1=0xBB.. with WLAST=1, BREADY=1.
   -> Required: O_HDR_VALID pulse; payload {0,AA..} FIRST then BB.. LAST; BRESP=00, BID=0; both error flags 0.
2. Same burst with header[99:96]=4'h2.
   -> Required: BRESP=10; O_HDR_ERR=1; payload still streamed.
3. Three single-beat bursts: SOM/SEQ0, SEQ1, EOM/SEQ2, all TAG=3.
   -> Required: all BRESP=00; O_SEQ_ERR=0.
   Then SOM/SEQ3 followed by SEQ0: the second is accepted (wrap 3->0).
4. SOM/SEQ0 then SEQ2 (skip).
   -> Required: second BRESP=10; O_SEQ_ERR=1; in_msg cleared, so a following SEQ3 (SOM=0) is also an error.
5. AWLEN=3 with WLAST on beat 1.
   -> Required: burst ends after 2 beats; BRESP=10; BVALID held 5 cycles with BREADY=0, then completes; AWREADY returns 1 the cycle after the B handshake.
6. Reset asserted during beat 1 of AWLEN=3.
   -> Required: all outputs 0 next cycle; no BVALID; AWREADY=1 the first cycle after release; a new valid burst completes with OKAY.
